// File: rtl/prbs4_checker.sv
// PRBS4 (x^4+x+1) stream checker: seeds, tracks, locks and counts bit errors.
// Latency: locked/err/err_count update on the clock edge after the accepted bit.
// Flow control: din_valid low freezes all state; no backpressure toward the source.
module prbs4_checker #(
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  input  logic        din_valid,
  input  logic        clr_err,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_TGT   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_TGT = 4'(UNLOCK_COUNT);

  state_t      state;
  logic [3:0]  hist;      // hist[0] oldest bit, hist[3] newest
  logic [1:0]  seed_cnt;
  logic [3:0]  good_cnt;
  logic [3:0]  bad_cnt;

  logic        pred;
  logic        mismatch;
  logic        hist_zero;
  logic [3:0]  good_inc;
  logic [3:0]  bad_inc;
  logic [15:0] cnt_base;
  logic [15:0] cnt_inc;

  // Prediction, compare and counter increments derived from current state.
  // cnt_base folds in clr_err so a clear and a counted mismatch in the same
  // cycle yield a count of one.
  always_comb begin
    pred      = hist[0] ^ hist[1];
    mismatch  = din ^ pred;
    hist_zero = (hist == 4'd0);
    good_inc  = good_cnt + 4'd1;
    bad_inc   = bad_cnt + 4'd1;
    cnt_base  = clr_err ? 16'd0 : err_count;
    cnt_inc   = (cnt_base == 16'hFFFF) ? cnt_base : cnt_base + 16'd1;
  end

  // Checker FSM with registered outputs; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SEED;
      hist      <= 4'd0;
      seed_cnt  <= 2'd0;
      good_cnt  <= 4'd0;
      bad_cnt   <= 4'd0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= 16'd0;
    end else begin
      err       <= 1'b0;
      err_count <= cnt_base;
      if (din_valid) begin
        unique case (state)
          SEED: begin
            hist <= {din, hist[3:1]};
            if (seed_cnt == 2'd3) begin
              state    <= TRACK;
              seed_cnt <= 2'd0;
              good_cnt <= 4'd0;
            end else begin
              seed_cnt <= seed_cnt + 2'd1;
            end
          end
          TRACK: begin
            // An all-zero history is the PRBS lock-up state and never counts
            // toward lock even though it predicts itself correctly.
            hist <= {din, hist[3:1]};
            if (mismatch || hist_zero) begin
              good_cnt <= 4'd0;
            end else if (good_inc == LOCK_TGT) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              good_cnt <= 4'd0;
              bad_cnt  <= 4'd0;
            end else begin
              good_cnt <= good_inc;
            end
          end
          LOCKED: begin
            // Free-run the reference so one corrupted bit is one error only.
            hist <= {pred, hist[3:1]};
            if (mismatch) begin
              err       <= 1'b1;
              err_count <= cnt_inc;
              if (bad_inc == UNLOCK_TGT) begin
                state    <= TRACK;
                locked   <= 1'b0;
                good_cnt <= 4'd0;
                bad_cnt  <= 4'd0;
              end else begin
                bad_cnt <= bad_inc;
              end
            end else begin
              bad_cnt <= 4'd0;
            end
          end
          default: begin
            state    <= SEED;
            locked   <= 1'b0;
            seed_cnt <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs4_checker.sv
module tb_prbs4_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, din, din_valid, clr_err;
  logic        locked, err;
  logic [15:0] err_count;

  logic        reset2, din2, din_valid2, clr_err2;
  logic        locked2, err2;
  logic [15:0] err_count2;

  prbs4_checker dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .clr_err(clr_err), .locked(locked), .err(err), .err_count(err_count)
  );

  prbs4_checker #(.LOCK_COUNT(8), .UNLOCK_COUNT(15)) dut_sat (
    .clk(clk), .reset(reset2), .din(din2), .din_valid(din_valid2),
    .clr_err(clr_err2), .locked(locked2), .err(err2), .err_count(err_count2)
  );

  int n_vec = 0;
  int n_bad = 0;

  bit seq [15] = '{0,0,0,1,0,0,1,1,0,1,0,1,1,1,1};

  function automatic bit sb(input int k);
    return seq[k % 15];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step1(input logic r, input logic v, input logic d, input logic c);
    reset = r; din_valid = v; din = d; clr_err = c;
    @(posedge clk); #1;
  endtask

  task automatic step2(input logic r, input logic v, input logic d, input logic c);
    reset2 = r; din_valid2 = v; din2 = d; clr_err2 = c;
    @(posedge clk); #1;
  endtask

  // Table of directed vectors
  typedef struct packed {
    logic        rst, dv, din, clr, e_locked, e_err;
    logic [15:0] e_cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic r, input logic v, input logic d, input logic c,
                              input logic l, input logic e, input logic [15:0] n);
    vec_t t;
    t.rst = r; t.dv = v; t.din = d; t.clr = c;
    t.e_locked = l; t.e_err = e; t.e_cnt = n;
    tbl.push_back(t);
  endfunction

  // Behavioural reference: mode 0 = seeding, 1 = tracking, 2 = locked.
  // History holds the last four reference bits, oldest first; the next
  // expected bit is s[n] ^ s[n+1].
  int m_mode, m_seen, m_good, m_bad, m_cnt;
  bit m_h[$];
  bit m_locked, m_err;

  task automatic model(input bit r, input bit v, input bit d, input bit c);
    bit pb, nonzero;
    if (!r) begin
      m_mode = 0; m_h = '{0,0,0,0}; m_seen = 0; m_good = 0; m_bad = 0;
      m_locked = 0; m_err = 0; m_cnt = 0;
      return;
    end
    m_err = 0;
    if (c) m_cnt = 0;
    if (!v) return;
    pb = m_h[0] ^ m_h[1];
    nonzero = m_h[0] | m_h[1] | m_h[2] | m_h[3];
    if (m_mode == 0) begin
      m_h.push_back(d); void'(m_h.pop_front());
      m_seen++;
      if (m_seen == 4) begin m_mode = 1; m_good = 0; end
    end else if (m_mode == 1) begin
      m_h.push_back(d); void'(m_h.pop_front());
      if (d == pb && nonzero) m_good++; else m_good = 0;
      if (m_good == 8) begin m_mode = 2; m_locked = 1; m_bad = 0; m_good = 0; end
    end else begin
      m_h.push_back(pb); void'(m_h.pop_front());
      if (d != pb) begin
        m_err = 1;
        m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        m_bad++;
        if (m_bad == 3) begin m_mode = 1; m_locked = 0; m_good = 0; m_bad = 0; end
      end else begin
        m_bad = 0;
      end
    end
  endtask

  initial begin
    int idx, burst, zrun, j, errs_seen, lost_lock;
    bit rr, rv, rd, rc;

    reset = 0; din = 0; din_valid = 0; clr_err = 0;
    reset2 = 0; din2 = 0; din_valid2 = 0; clr_err2 = 0;

    // ---------------- directed table ----------------
    add(0, 1, 1, 1, 0, 0, 16'd0);                       // reset beats dv/clr
    for (int k = 0; k < 12; k++) add(1, 1, sb(k), 0, (k == 11), 0, 16'd0);
    for (int k = 12; k < 15; k++) add(1, 1, sb(k), 0, 1, 0, 16'd0);
    add(1, 1, !sb(15), 0, 1, 1, 16'd1);                 // single bit error
    add(1, 1, sb(16), 0, 1, 0, 16'd1);
    for (int k = 17; k < 20; k++) add(1, 1, !sb(k), 0, (k != 19), 1, 16'(k - 15));
    for (int k = 20; k < 28; k++) add(1, 1, sb(k), 0, (k == 27), 0, 16'd4);
    for (int i = 0; i < 5; i++) add(1, 0, 1'($urandom_range(0, 1)), 0, 1, 0, 16'd4);
    for (int k = 28; k < 32; k++) add(1, 1, sb(k), 0, 1, 0, 16'd4);
    add(1, 0, 0, 1, 1, 0, 16'd0);                       // clear while idle
    add(1, 1, !sb(32), 1, 1, 1, 16'd1);                 // clear with mismatch
    add(1, 1, sb(33), 0, 1, 0, 16'd1);
    add(0, 1, sb(34), 0, 0, 0, 16'd0);                  // reset mid-lock
    for (int i = 0; i < 64; i++) add(1, 1, 0, 0, 0, 0, 16'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      step1(tbl[i].rst, tbl[i].dv, tbl[i].din, tbl[i].clr);
      check($sformatf("row%0d_locked", i), locked, tbl[i].e_locked);
      check($sformatf("row%0d_err", i), err, tbl[i].e_err);
      check($sformatf("row%0d_cnt", i), err_count, tbl[i].e_cnt);
    end

    // ---------------- randomized vs reference model ----------------
    idx = 0; burst = 0; zrun = 0;
    for (int i = 0; i < 3000; i++) begin
      rr = (i != 0) && ($urandom_range(0, 599) != 0);
      rv = ($urandom_range(0, 7) != 0);
      rc = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 399) == 0) idx += $urandom_range(1, 14);
      if (zrun == 0 && $urandom_range(0, 499) == 0) zrun = $urandom_range(4, 20);
      if (burst == 0 && $urandom_range(0, 59) == 0) burst = $urandom_range(1, 4);
      if (zrun > 0) rd = 0;
      else rd = sb(idx) ^ ((burst > 0) || ($urandom_range(0, 49) == 0));
      if (rv) begin
        idx++;
        if (burst > 0) burst--;
        if (zrun > 0) zrun--;
      end
      step1(rr, rv, rd, rc);
      model(rr, rv, rd, rc);
      check($sformatf("rnd%0d_locked", i), locked, m_locked);
      check($sformatf("rnd%0d_err", i), err, m_err);
      check($sformatf("rnd%0d_cnt", i), err_count, m_cnt);
    end

    // ---------------- saturation sequence (UNLOCK_COUNT = 15) ----------------
    step2(0, 0, 0, 0);
    check("sat_reset_cnt", err_count2, 16'd0);
    j = 0;
    for (int k = 0; k < 12; k++) begin step2(1, 1, sb(j), 0); j++; end
    check("sat_lock", locked2, 1'b1);
    errs_seen = 0; lost_lock = 0;
    for (int g = 0; g < 4681; g++) begin
      for (int k = 0; k < 14; k++) begin
        step2(1, 1, !sb(j), 0); j++;
        errs_seen += int'(err2);
        lost_lock += int'(!locked2);
      end
      step2(1, 1, sb(j), 0); j++;
      errs_seen += int'(err2);
      lost_lock += int'(!locked2);
    end
    step2(1, 1, !sb(j), 0); j++;
    errs_seen += int'(err2);
    check("sat_reach_cnt", err_count2, 16'hFFFF);
    check("sat_err_pulses", errs_seen, 65535);
    check("sat_lock_held", lost_lock, 0);
    step2(1, 1, !sb(j), 0); j++;
    check("sat_hold_cnt", err_count2, 16'hFFFF);
    check("sat_hold_err", err2, 1'b1);
    check("sat_hold_locked", locked2, 1'b1);
    step2(1, 1, !sb(j), 1); j++;
    check("sat_clr_cnt", err_count2, 16'd1);
    check("sat_clr_err", err2, 1'b1);
    step2(0, 1, !sb(j), 1); j++;
    check("sat_rst_locked", locked2, 1'b0);
    check("sat_rst_cnt", err_count2, 16'd0);
    check("sat_rst_err", err2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/prbs4_checker.md
PRBS4_CHECKER -- requirements
Module: prbs4_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 8, consecutive correct predicted bits needed to lock, legal range 1..15.
REQ-002 Parameter UNLOCK_COUNT, default 3, consecutive mismatches while locked needed to drop lock, legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 din  input  1  received serial bit of the PRBS4 stream.
REQ-006 din_valid  input  1  din qualifier; the block ignores din when low.
REQ-007 clr_err  input  1  synchronous clear of err_count.
REQ-008 locked  output  1  high while the checker is locked to the stream.
REQ-009 err  output  1  one-cycle pulse per mismatched bit while locked.
REQ-010 err_count  output  16  saturating count of mismatches while locked.

Function
REQ-011 The reference sequence SHALL be s[n+4] = s[n] XOR s[n+1] (x^4+x+1), period 15; e.g. 0,0,0,1,0,0,1,1,0,1,0,1,1,1,1 repeating.
REQ-012 The block SHALL hold a 4-bit history R: on each accepted bit, R[2:0] <= R[3:1] and R[3] <= shifted-in bit; the prediction is p = R[0] XOR R[1].
REQ-013 The FSM SHALL have states SEED, TRACK and LOCKED; a cycle with din_valid low SHALL change no state, counter or history.
REQ-014 SEED: shift din into R and count accepted bits 0..3; after the 4th, go to TRACK with good_cnt = 0.
REQ-015 TRACK: shift din into R and compare din with p; on a match with R != 0000, good_cnt += 1; on a mismatch or R == 0000, good_cnt = 0.
REQ-016 TRACK: when good_cnt reaches LOCK_COUNT, go to LOCKED and clear bad_cnt; locked SHALL rise the cycle after the accepted bit that completes the count.
REQ-017 LOCKED: shift p (not din) into R, so the reference free-runs and a single corrupted bit yields exactly one mismatch.
REQ-018 LOCKED: on a mismatch, pulse err high for one cycle (the cycle after the accepted bit), increment err_count, and increment bad_cnt; on a match, clear bad_cnt.
REQ-019 LOCKED: when bad_cnt reaches UNLOCK_COUNT, go to TRACK with good_cnt = 0; locked SHALL fall the cycle after that bit.
REQ-020 On leaving LOCKED, R SHALL keep its content, and TRACK SHALL resume shifting din.
REQ-021 err_count SHALL saturate at 16'hFFFF and never wrap.
REQ-022 clr_err SHALL set err_count to 0; if it coincides with a counted mismatch, err_count SHALL become 1 and the err pulse SHALL still occur.
REQ-023 err SHALL never assert outside LOCKED; locked, err and err_count SHALL be registered outputs.

Reset
REQ-024 While reset is low at a clock edge, the FSM SHALL go to SEED, and R, the seed count, good_cnt and bad_cnt SHALL clear; locked = 0, err = 0, err_count = 0.
REQ-025 Reset SHALL take priority over din_valid and clr_err, including in the middle of lock.

Verification
REQ-026 Reset, then feed the sequence in REQ-011 continuously with din_valid = 1 -> locked rises the cycle after the 12th bit (LOCK_COUNT = 8); err stays 0; err_count = 0.
REQ-027 While locked, invert one bit -> exactly one err pulse; err_count = 1; locked stays 1.
REQ-028 While locked, invert 3 consecutive bits -> err_count increases by 3; locked falls the cycle after the 3rd inverted bit; correct data then relocks after 8 matches.
REQ-029 Feed 64 consecutive 0 bits -> locked never asserts; err = 0; err_count = 0.
REQ-030 While locked, hold din_valid low for 5 cycles with random din, then resume the sequence -> no err pulses; locked held throughout.
REQ-031 Force err_count to 16'hFFFF by injected errors, then inject one more error -> err_count stays FFFF; then assert clr_err together with a mismatch -> err_count = 1; then pull reset low mid-lock -> locked = 0, err_count = 0 on the next edge.
